// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions.
//   NB          : state width in 32-bit words (fixed at 4)
//   nr_of(nk)   : number of rounds for a key of nk words
//   sbox(b)     : forward AES S-box lookup
//   xtime(b)    : multiply by x in GF(2^8) (used to advance rcon)
//   ks_state_e  : key-schedule controller states
//   round_key_t : one 128-bit round key
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} ks_state_e;

  typedef logic [127:0] round_key_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word   in  32  word to substitute
//   subbed out 32  four parallel S-box lookups, byte positions preserved
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign subbed[8*gi +: 8] = sbox(word[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule engine and round-key store.
// A start pulse (in IDLE or DONE) latches key_in and then one expanded word
// is produced per clock until all NR+1 round keys are stored.
//   clk, rst     clock / synchronous active-high reset
//   start        request expansion of key_in (ignored while busy)
//   key_in       cipher key, byte 0 in the most significant byte
//   busy         expansion in progress
//   done         one-cycle pulse on the edge that writes the last word
//   keys_valid   all round keys stored and readable
//   rk_rd_en     round-key read strobe
//   rk_idx       round index 0..NR
//   rk_data      registered round key (0 when keys invalid or index > NR)
//   rk_rd_valid  high the cycle after rk_rd_en
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            done,
  output logic            keys_valid,
  input  logic            rk_rd_en,
  input  logic [3:0]      rk_idx,
  output logic [127:0]    rk_data,
  output logic            rk_rd_valid
);

  localparam int NR = nr_of(NK);
  localparam int NW = NB * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST_I = IW'(NW - 1);
  localparam logic [IW-1:0] FIRST_I = IW'(NK);
  localparam logic [2:0] LAST_PHASE = 3'(NK - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_EXPAND = EXPAND;
  localparam logic [1:0] S_DONE   = DONE;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_key_sched_ctrl: NK must be 4, 6 or 8");
  end

  logic [1:0]    state_reg;
  logic [IW-1:0] i_reg;
  logic [2:0]    phase_reg;   // i mod NK, tracked incrementally
  logic [7:0]    rcon_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          keys_valid_reg;
  logic          rd_valid_reg;
  round_key_t    rk_data_reg;

  logic [31:0] w_mem   [NW];
  // Sliding window of the last NK words: win_reg[0] = w[i-NK], win_reg[NK-1] = w[i-1].
  logic [31:0] win_reg [NK];

  logic        load;
  logic [31:0] prev_word;
  logic [31:0] rot_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_word;
  logic [31:0] new_word;

  assign load = start && (state_reg == S_IDLE || state_reg == S_DONE);

  assign prev_word = win_reg[NK-1];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};
  assign sub_in    = (phase_reg == 3'd0) ? rot_word : prev_word;

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .subbed (sub_out)
  );

  // Only AES-256 applies the extra SubWord at i mod NK == 4.
  assign temp_word = (phase_reg == 3'd0)              ? (sub_out ^ {rcon_reg, 24'h000000}) :
                     (NK == 8 && phase_reg == 3'd4)   ? sub_out :
                                                        prev_word;
  assign new_word  = win_reg[0] ^ temp_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      i_reg          <= '0;
      phase_reg      <= 3'd0;
      rcon_reg       <= 8'h01;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      keys_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            i_reg          <= FIRST_I;
            phase_reg      <= 3'd0;
            rcon_reg       <= 8'h01;
            busy_reg       <= 1'b1;
            keys_valid_reg <= 1'b0;
            state_reg      <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          i_reg     <= i_reg + IW'(1);
          phase_reg <= (phase_reg == LAST_PHASE) ? 3'd0 : phase_reg + 3'd1;
          if (phase_reg == 3'd0) begin
            rcon_reg <= xtime(rcon_reg);
          end
          if (i_reg == LAST_I) begin
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            keys_valid_reg <= 1'b1;
            state_reg      <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Word store and window; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && load) begin
      for (int k = 0; k < NK; k++) begin
        w_mem[IW'(k)] <= key_in[32*(NK-1-k) +: 32];
        win_reg[k]    <= key_in[32*(NK-1-k) +: 32];
      end
    end else if (!rst && state_reg == S_EXPAND) begin
      w_mem[i_reg] <= new_word;
      for (int k = 0; k < NK - 1; k++) begin
        win_reg[k] <= win_reg[k+1];
      end
      win_reg[NK-1] <= new_word;
    end
  end

  logic          rk_in_range;
  logic [3:0]    rd_sel;
  logic [IW-1:0] rd_base;

  assign rk_in_range = ({28'd0, rk_idx} <= 32'(NR));
  assign rd_sel      = rk_in_range ? rk_idx : 4'd0;   // keeps the array index in range
  assign rd_base     = IW'({rd_sel, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rk_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rk_rd_en;
      if (rk_rd_en) begin
        rk_data_reg <= (keys_valid_reg && rk_in_range) ?
                       {w_mem[rd_base], w_mem[rd_base + IW'(1)],
                        w_mem[rd_base + IW'(2)], w_mem[rd_base + IW'(3)]} : '0;
      end
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign keys_valid  = keys_valid_reg;
  assign rk_data     = rk_data_reg;
  assign rk_rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: one instance per key size
// (sel 0/1/2 = NK 4/6/8), checked against FIPS-197 vectors and a reference
// key expansion whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_sched_ctrl;

  logic clk;
  logic rst;
  logic [2:0]   start_v;
  logic [255:0] key_v [3];
  logic [2:0]   busy_v, done_v, kv_v, rv_v, rd_en_v;
  logic [3:0]   idx_v  [3];
  logic [127:0] data_v [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  tsbox [256];
  logic [31:0] mw    [60];

  aes_key_sched_ctrl #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key_v[0][127:0]),
    .busy(busy_v[0]), .done(done_v[0]), .keys_valid(kv_v[0]),
    .rk_rd_en(rd_en_v[0]), .rk_idx(idx_v[0]), .rk_data(data_v[0]), .rk_rd_valid(rv_v[0]));

  aes_key_sched_ctrl #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key_v[1][191:0]),
    .busy(busy_v[1]), .done(done_v[1]), .keys_valid(kv_v[1]),
    .rk_rd_en(rd_en_v[1]), .rk_idx(idx_v[1]), .rk_data(data_v[1]), .rk_rd_valid(rv_v[1]));

  aes_key_sched_ctrl #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .keys_valid(kv_v[2]),
    .rk_rd_en(rd_en_v[2]), .rk_idx(idx_v[2]), .rk_data(data_v[2]), .rk_rd_valid(rv_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      tsbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tsbox[w[31:24]], tsbox[w[23:16]], tsbox[w[15:8]], tsbox[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int k = 0; k < nk; k++) mw[k] = key[32*(nk-1-k) +: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input int sel, input logic [255:0] key);
    @(negedge clk);
    key_v[sel] = key;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Latency counted in cycles after the start edge; -1 if the bound expires.
  task automatic wait_done(input int sel, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done_v[sel]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic rd(input int sel, input int idx, output logic [127:0] d);
    @(negedge clk);
    rd_en_v[sel] = 1'b1;
    idx_v[sel] = 4'(idx);
    @(negedge clk);
    rd_en_v[sel] = 1'b0;
    chkb("rd_valid", rv_v[sel], 1'b1);
    d = data_v[sel];
    $display("read nk=%0d idx=%0d data=%h", 4 + 2 * sel, idx, d);
  endtask

  task automatic check_all(input int sel, input logic [255:0] key);
    logic [127:0] d;
    int nk;
    nk = 4 + 2 * sel;
    model_expand(key, nk);
    for (int r = 0; r <= nk + 6; r++) begin
      rd(sel, r, d);
      chk($sformatf("rk nk%0d idx%0d", nk, r), d, model_rk(r));
    end
  endtask

  task automatic run_key(input int sel, input logic [255:0] key);
    int lat;
    int nk;
    nk = 4 + 2 * sel;
    do_start(sel, key);
    chkb("busy_after_start", busy_v[sel], 1'b1);
    wait_done(sel, lat);
    chki($sformatf("latency nk%0d", nk), lat, 4 * (nk + 7) - nk);
    chkb("kv_at_done", kv_v[sel], 1'b1);
    chkb("busy_at_done", busy_v[sel], 1'b0);
    $display("expand nk=%0d key=%h latency=%0d", nk, key, lat);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [255:0] KEY4 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] KEY6 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [127:0] d;
    logic [255:0] rkey;
    int lat;
    int seen;

    rst = 1'b1;
    start_v = '0;
    rd_en_v = '0;
    for (int s = 0; s < 3; s++) begin
      key_v[s] = '0;
      idx_v[s] = '0;
    end
    build_sbox();

    repeat (3) @(negedge clk);
    chkb("rst_busy", busy_v[0], 1'b0);
    chkb("rst_done", done_v[0], 1'b0);
    chkb("rst_kv", kv_v[0], 1'b0);
    chkb("rst_rv", rv_v[0], 1'b0);
    chk("rst_data", data_v[0], 128'h0);
    chkb("rst_busy6", busy_v[1], 1'b0);
    chkb("rst_busy8", busy_v[2], 1'b0);
    rst = 1'b0;

    rd(0, 0, d);
    chk("rd_before_keys", d, 128'h0);

    // FIPS-197 vectors
    run_key(0, KEY4);
    rd(0, 1, d);  chk("nk4_idx1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(0, 10, d); chk("nk4_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(0, 0, d);  chk("nk4_idx0", d, KEY4[127:0]);
    @(negedge clk);
    chkb("rd_valid_drops", rv_v[0], 1'b0);
    check_all(0, KEY4);
    rd(0, 11, d); chk("nk4_idx11_oob", d, 128'h0);
    rd(0, 15, d); chk("nk4_idx15_oob", d, 128'h0);

    run_key(1, KEY6);
    rd(1, 12, d); chk("nk6_idx12", d, 128'he98ba06f448c773c8ecc720401002202);
    check_all(1, KEY6);

    run_key(2, KEY8);
    rd(2, 14, d); chk("nk8_idx14", d, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(2, 15, d); chk("nk8_idx15_oob", d, 128'h0);
    check_all(2, KEY8);

    // random keys against the reference model
    for (int it = 0; it < 2; it++) begin
      for (int s = 0; s < 3; s++) begin
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (s == 0) rkey[255:128] = '0;
        if (s == 1) rkey[255:192] = '0;
        run_key(s, rkey);
        check_all(s, rkey);
      end
    end

    // start and key_in changes during expansion are ignored
    do_start(0, KEY4);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 20) begin
        start_v[0] = 1'b1;
        key_v[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (n == 21) start_v[0] = 1'b0;
      if (done_v[0]) begin
        lat = n;
        break;
      end
    end
    chki("latency_ignore_start", lat, 40);
    rd(0, 10, d); chk("ignore_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(0, 1, d);  chk("ignore_idx1", d, 128'ha0fafe1788542cb123a339392a6c7605);

    // read during expansion, then reset mid-expansion
    do_start(0, KEY4);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 5) begin
        rd_en_v[0] = 1'b1;
        idx_v[0] = 4'd1;
      end
      if (n == 6) begin
        rd_en_v[0] = 1'b0;
        chkb("rd_valid_expand", rv_v[0], 1'b1);
        chk("rd_during_expand", data_v[0], 128'h0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chkb("midrst_busy", busy_v[0], 1'b0);
    chkb("midrst_kv", kv_v[0], 1'b0);
    chkb("midrst_done", done_v[0], 1'b0);
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    chki("no_done_after_rst", seen, 0);
    rd(0, 1, d); chk("midrst_idx1", d, 128'h0);
    run_key(0, KEY4);
    rd(0, 1, d); chk("after_rst_idx1", d, 128'ha0fafe1788542cb123a339392a6c7605);

    // re-expansion from DONE
    chkb("kv_before_restart", kv_v[0], 1'b1);
    do_start(0, KEY4);
    chkb("kv_drops_at_restart", kv_v[0], 1'b0);
    wait_done(0, lat);
    chki("latency_restart", lat, 40);
    chkb("kv_rises_again", kv_v[0], 1'b1);
    @(negedge clk);
    chkb("done_one_cycle", done_v[0], 1'b0);
    rd(0, 10, d); chk("restart_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
